// File: rtl/qpsk_rx_pkg.sv
// Shared types and helpers for the fs/4-IF QPSK receive path: accumulator sizing,
// carrier-phase encodings, rail operations and ADC offset-binary conversion.
package qpsk_rx_pkg;

    localparam int ADC_W = 14;

    // The order follows the fs/4 local oscillator: +I, -Q, -I, +Q.
    typedef enum logic [1:0] {
        P_I_POS = 2'd0,
        P_Q_NEG = 2'd1,
        P_I_NEG = 2'd2,
        P_Q_POS = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2
    } rail_op_e;

    function automatic int acc_width(input int sps);
        return ADC_W + $clog2(sps);
    endfunction

    function automatic logic signed [ADC_W-1:0] ob_to_tc(input logic [ADC_W-1:0] ob);
        return signed'({~ob[ADC_W-1], ob[ADC_W-2:0]});
    endfunction

endpackage

// File: rtl/qpsk_rx_integrator.sv
// One signed integrate-and-dump rail: add, subtract or hold each sample, capture the
// final sum on dump, and restart from zero on dump or clear.
module qpsk_rx_integrator
    import qpsk_rx_pkg::*;
#(
    parameter int IN_W  = 14,
    parameter int ACC_W = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  rail_op_e                op,
    input  logic                    dump,
    input  logic                    clear,
    input  logic signed [IN_W-1:0]  sample,
    output logic signed [ACC_W-1:0] dump_val
);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] dump_q, dump_d;
    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W-1:0] sum;

    always_comb begin
        ext = {{(ACC_W-IN_W){sample[IN_W-1]}}, sample};
        sum = acc_q;
        unique case (op)
            OP_ADD:  sum = acc_q + ext;
            OP_SUB:  sum = acc_q - ext;
            default: sum = acc_q;
        endcase
        // The dumped value includes the sample arriving on the dump cycle.
        dump_d = dump ? sum : dump_q;
        acc_d  = (dump || clear) ? '0 : sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            dump_q <= '0;
        end else begin
            acc_q  <= acc_d;
            dump_q <= dump_d;
        end
    end

    assign dump_val = dump_q;

endmodule

// File: rtl/receive_qpsk.sv
// fs/4-IF QPSK demodulator: offset-binary ADC in, integrate-and-dump per rail, hard
// dibits plus soft sums out. Define RX_DC_BLOCK_EN to add a DC-tracking stage before mixing.
module receive_qpsk
    import qpsk_rx_pkg::*;
#(
    parameter int SPS      = 20,
    parameter int DC_SHIFT = 10,
    parameter int ACC_W    = acc_width(SPS)
) (
    input  logic                    clock_5000,
    input  logic                    reset,
    input  logic [13:0]             adc_in,
    input  logic                    align,
    output logic [1:0]              sym_out,
    output logic                    sym_valid,
    output logic signed [ACC_W-1:0] soft_i,
    output logic signed [ACC_W-1:0] soft_q,
    output logic [15:0]             sym_count
);

    localparam int CNT_W = $clog2(SPS);
    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(SPS - 1);

    if (SPS < 4 || SPS > 1024 || (SPS % 4) != 0 || DC_SHIFT < 1) begin : g_param_check
        $error("receive_qpsk: SPS must be a multiple of 4 in 4..1024 and DC_SHIFT >= 1");
    end

    logic signed [ADC_W-1:0] x_q, x_d;
    logic                    x_vld_q, x_vld_d;
    logic signed [ADC_W-1:0] mix_s;
    logic                    mix_vld;
    phase_e                  p_q, p_d;
    logic [CNT_W-1:0]        n_q, n_d;
    logic                    dump, align_eff;
    rail_op_e                op_i, op_q;
    logic signed [ACC_W-1:0] dump_i, dump_q;
    logic                    dump_pend_q, dump_pend_d;
    logic                    sym_valid_q, sym_valid_d;
    logic [1:0]              sym_out_q, sym_out_d;
    logic signed [ACC_W-1:0] soft_i_q, soft_i_d, soft_q_q, soft_q_d;
    logic [15:0]             sym_count_q, sym_count_d;

`ifdef RX_DC_BLOCK_EN
    localparam int DC_W = ADC_W + DC_SHIFT;

    logic signed [DC_W-1:0]  dc_est_q, dc_est_d;
    logic signed [DC_W-1:0]  dc_mean;
    logic signed [ADC_W:0]   y_full;
    logic signed [ADC_W-1:0] y_q, y_d;
    logic                    y_vld_q, y_vld_d;

    always_comb begin
        dc_mean = dc_est_q >>> DC_SHIFT;
        y_full  = {x_q[ADC_W-1], x_q} - dc_mean[ADC_W:0];
        // Clamp so the mixer input keeps the ADC range and the accumulators cannot overflow.
        if (y_full > 15'sd8191)       y_d = 14'sd8191;
        else if (y_full < -15'sd8192) y_d = -14'sd8192;
        else                          y_d = y_full[ADC_W-1:0];
        y_vld_d  = x_vld_q && !align_eff;
        dc_est_d = x_vld_q ? dc_est_q + {{(DC_W-ADC_W){y_d[ADC_W-1]}}, y_d} : dc_est_q;
    end

    always_ff @(posedge clock_5000) begin
        if (reset) begin
            dc_est_q <= '0;
            y_q      <= '0;
            y_vld_q  <= 1'b0;
        end else begin
            dc_est_q <= dc_est_d;
            y_q      <= y_d;
            y_vld_q  <= y_vld_d;
        end
    end

    assign mix_s   = y_q;
    assign mix_vld = y_vld_q;
`else
    assign mix_s   = x_q;
    assign mix_vld = x_vld_q;
`endif

    always_comb begin
        dump = mix_vld && (n_q == N_LAST);
        // An align landing on a dump is absorbed: the dump already restarts the window.
        align_eff = align && !dump;

        x_d     = ob_to_tc(adc_in);
        x_vld_d = !align_eff;

        p_d = mix_vld ? phase_e'(p_q + 2'd1) : p_q;
        n_d = n_q;
        if (align_eff || dump) n_d = '0;
        else if (mix_vld)      n_d = n_q + CNT_W'(1);

        op_i = OP_HOLD;
        op_q = OP_HOLD;
        if (mix_vld) begin
            unique case (p_q)
                P_I_POS: op_i = OP_ADD;
                P_Q_NEG: op_q = OP_SUB;
                P_I_NEG: op_i = OP_SUB;
                P_Q_POS: op_q = OP_ADD;
                default: op_i = OP_HOLD;
            endcase
        end

        // sym_valid is a one-cycle strobe with no backpressure; outputs hold between strobes.
        dump_pend_d = dump;
        sym_valid_d = dump_pend_q;
        sym_out_d   = sym_out_q;
        soft_i_d    = soft_i_q;
        soft_q_d    = soft_q_q;
        sym_count_d = sym_count_q;
        if (dump_pend_q) begin
            soft_i_d    = dump_i;
            soft_q_d    = dump_q;
            sym_out_d   = {dump_i[ACC_W-1], dump_q[ACC_W-1]};
            sym_count_d = sym_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock_5000) begin
        if (reset) begin
            x_q         <= '0;
            x_vld_q     <= 1'b0;
            p_q         <= P_I_POS;
            n_q         <= '0;
            dump_pend_q <= 1'b0;
            sym_valid_q <= 1'b0;
            sym_out_q   <= '0;
            soft_i_q    <= '0;
            soft_q_q    <= '0;
            sym_count_q <= '0;
        end else begin
            x_q         <= x_d;
            x_vld_q     <= x_vld_d;
            p_q         <= p_d;
            n_q         <= n_d;
            dump_pend_q <= dump_pend_d;
            sym_valid_q <= sym_valid_d;
            sym_out_q   <= sym_out_d;
            soft_i_q    <= soft_i_d;
            soft_q_q    <= soft_q_d;
            sym_count_q <= sym_count_d;
        end
    end

    qpsk_rx_integrator #(.IN_W(ADC_W), .ACC_W(ACC_W)) u_rail_i (
        .clk      (clock_5000),
        .rst      (reset),
        .op       (op_i),
        .dump     (dump),
        .clear    (align_eff),
        .sample   (mix_s),
        .dump_val (dump_i)
    );

    qpsk_rx_integrator #(.IN_W(ADC_W), .ACC_W(ACC_W)) u_rail_q (
        .clk      (clock_5000),
        .rst      (reset),
        .op       (op_q),
        .dump     (dump),
        .clear    (align_eff),
        .sample   (mix_s),
        .dump_val (dump_q)
    );

    assign sym_out   = sym_out_q;
    assign sym_valid = sym_valid_q;
    assign soft_i    = soft_i_q;
    assign soft_q    = soft_q_q;
    assign sym_count = sym_count_q;

endmodule

// File: tb/tb_receive_qpsk.sv
// Directed bench for receive_qpsk (default build): phase-matched symbols are driven,
// expected strobes are queued with their due cycle and compared when the DUT emits them.
module tb_receive_qpsk;

    localparam int SPS   = 20;
    localparam int ACC_W = 19;
    localparam int Q4    = SPS / 4;

    logic                    clock_5000 = 1'b0;
    logic                    reset      = 1'b1;
    logic                    align      = 1'b0;
    logic [13:0]             adc_in     = 14'h2000;
    logic [1:0]              sym_out;
    logic                    sym_valid;
    logic signed [ACC_W-1:0] soft_i;
    logic signed [ACC_W-1:0] soft_q;
    logic [15:0]             sym_count;

    receive_qpsk #(.SPS(SPS)) dut (
        .clock_5000 (clock_5000),
        .reset      (reset),
        .adc_in     (adc_in),
        .align      (align),
        .sym_out    (sym_out),
        .sym_valid  (sym_valid),
        .soft_i     (soft_i),
        .soft_q     (soft_q),
        .sym_count  (sym_count)
    );

    always #5 clock_5000 = ~clock_5000;

    typedef struct {
        int         cyc;
        int         si;
        int         sq;
        logic [1:0] sym;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];

    int         checks    = 0;
    int         errors    = 0;
    int         cyc       = 0;
    int         p_m       = 0;
    int         exp_count = 0;
    int         last_si   = 0;
    int         last_sq   = 0;
    int         last_cnt  = 0;
    logic [1:0] last_sym  = 2'b00;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive inputs, let the edge pass, then check the outputs against the queue.
    task automatic step(input int v_adc, input bit al, input bit rs);
        exp_t e;
        bit   exp_v;
        adc_in = 14'(v_adc);
        align  = al;
        reset  = rs;
        if (rs) begin
            exp_q.delete();
            last_si   = 0;
            last_sq   = 0;
            last_cnt  = 0;
            last_sym  = 2'b00;
            exp_count = 0;
            p_m       = 0;
        end
        @(posedge clock_5000);
        #1;
        cyc++;
        exp_v = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc);
        chk("sym_valid", sym_valid, exp_v);
        if (exp_v) begin
            e = exp_q.pop_front();
            chk("soft_i", soft_i, e.si);
            chk("soft_q", soft_q, e.sq);
            chk("sym_out", sym_out, e.sym);
            chk("sym_count", sym_count, e.cnt);
            last_si  = e.si;
            last_sq  = e.sq;
            last_sym = e.sym;
            last_cnt = e.cnt;
        end else begin
            chk("hold_soft_i", soft_i, last_si);
            chk("hold_soft_q", soft_q, last_sq);
            chk("hold_sym_out", sym_out, last_sym);
            chk("hold_sym_count", sym_count, last_cnt);
        end
    endtask

    task automatic send_sample(input int v, input bit al);
        step(v + 8192, al, 1'b0);
        p_m = (p_m + 1) % 4;
    endtask

    // Each window spans SPS/4 samples of every phase, so sums follow directly from v0..v3.
    task automatic send_symbol(input int v0, input int v1, input int v2, input int v3, input bit al_first);
        int   v[4];
        int   ei;
        int   eq;
        exp_t e;
        v  = '{v0, v1, v2, v3};
        ei = Q4 * (v0 - v2);
        eq = Q4 * (v3 - v1);
        for (int k = 0; k < SPS; k++) begin
            send_sample(v[p_m], al_first && (k == 0));
        end
        exp_count = (exp_count + 1) % 65536;
        e.cyc = cyc + 2;
        e.si  = ei;
        e.sq  = eq;
        e.sym = {ei < 0, eq < 0};
        e.cnt = exp_count;
        exp_q.push_back(e);
    endtask

    task automatic send_dibit(input logic [1:0] d, input bit al_first);
        int si;
        int sq;
        si = d[1] ? -1 : 1;
        sq = d[0] ? -1 : 1;
        send_symbol(4000 * si, -4000 * sq, -4000 * si, 4000 * sq, al_first);
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(0, 16383)) - 8192;
    endfunction

    initial begin
        repeat (3) step(8192, 1'b0, 1'b1);

        repeat (3) send_symbol(0, 0, 0, 0, 1'b0);

        for (int d = 0; d < 4; d++) send_dibit(2'(d), 1'b0);

        send_symbol(8191, 0, -8192, 0, 1'b0);

        repeat (3) send_symbol(rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample(), 1'b0);

        // align after 7 samples: the partial window is dropped and the align-cycle sample flushed.
        for (int k = 0; k < 7; k++) send_sample(rnd_sample(), 1'b0);
        step(8192 + 1234, 1'b1, 1'b0);
        send_dibit(2'b10, 1'b0);
        send_dibit(2'b01, 1'b0);
        // align coincident with the previous symbol's dump leaves the windowing unchanged.
        send_dibit(2'b11, 1'b1);

        for (int k = 0; k < 9; k++) send_sample(rnd_sample(), 1'b0);
        step(8192, 1'b0, 1'b1);
        send_dibit(2'b01, 1'b0);
        send_symbol(0, 0, 0, 0, 1'b0);

        repeat (4) send_sample(0, 1'b0);
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
